// File: rtl/gc_cfg_pkg.sv
// Shared definitions for the GC configuration dispatcher: opcodes, FSM states,
// error codes and header field positions.
package gc_cfg_pkg;

    localparam logic [3:0] OP_SEG = 4'h1;
    localparam logic [3:0] OP_END = 4'hF;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 28;
    localparam int TGT_MSB  = 27;
    localparam int TGT_LSB  = 24;
    localparam int CSUM_MSB = 15;
    localparam int CSUM_LSB = 0;
    localparam int CSUM_W   = CSUM_MSB - CSUM_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OPC  = 2'd1,
        ERR_TGT  = 2'd2,
        ERR_CSUM = 2'd3
    } err_code_t;

    // Segment counter holds at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gc_cfg_hdr_decode.sv
// Combinational classifier for one configuration header word.
module gc_cfg_hdr_decode
    import gc_cfg_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int LEN_W       = 16
) (
    input  logic [31:0]      hdr,
    output logic             is_seg,
    output logic             is_end,
    output logic             is_illegal,
    output logic [3:0]       tgt_id,
    output logic [LEN_W-1:0] len,
    output logic             tgt_oob
);

    logic [3:0] opcode;

    assign opcode     = hdr[OPC_MSB:OPC_LSB];
    assign tgt_id     = hdr[TGT_MSB:TGT_LSB];
    assign len        = hdr[LEN_W-1:0];
    assign is_seg     = (opcode == OP_SEG);
    assign is_end     = (opcode == OP_END);
    assign is_illegal = !is_seg && !is_end;
    assign tgt_oob    = ({28'd0, tgt_id} >= 32'(NUM_TARGETS));

    // Bits between the length field and the target id carry no meaning.
    generate
        if (LEN_W < TGT_LSB) begin : g_gap
            logic unused_gap_bits;
            assign unused_gap_bits = ^hdr[TGT_LSB-1:LEN_W];
        end
    endgenerate

endmodule

// File: rtl/gc_config_dispatcher.sv
// Parses the GC configuration word stream and routes segment payloads to one of
// NUM_TARGETS consumers. Optional END checksum check: define GC_CFG_CHECKSUM_EN.
module gc_config_dispatcher
    import gc_cfg_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int LEN_W       = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            src_data,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic [31:0]            tgt_data,
    output logic [NUM_TARGETS-1:0] tgt_valid,
    input  logic [NUM_TARGETS-1:0] tgt_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [7:0]             seg_count
);

    state_t                 state_reg;
    logic [NUM_TARGETS-1:0] sel_reg;
    logic [LEN_W-1:0]       remaining_reg;
    logic [7:0]             seg_count_reg;
    logic                   done_reg;
    logic                   err_reg;
    err_code_t              err_code_reg;

    logic                   hdr_is_seg;
    logic                   hdr_is_end;
    logic                   hdr_is_illegal;
    logic [3:0]             hdr_tgt_id;
    logic [LEN_W-1:0]       hdr_len;
    logic                   hdr_tgt_oob;
    logic [NUM_TARGETS-1:0] sel_dec;
    logic                   payload_ready;
    logic                   hs;
    logic                   end_ok;
    logic                   can_start;

    gc_cfg_hdr_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .LEN_W       (LEN_W)
    ) u_hdr_decode (
        .hdr        (src_data),
        .is_seg     (hdr_is_seg),
        .is_end     (hdr_is_end),
        .is_illegal (hdr_is_illegal),
        .tgt_id     (hdr_tgt_id),
        .len        (hdr_len),
        .tgt_oob    (hdr_tgt_oob)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_sel
            assign sel_dec[gi] = (hdr_tgt_id == 4'(gi));
        end
    endgenerate

    // Payload path is a straight pass-through; only the latched target sees valid.
    assign payload_ready = |(tgt_ready & sel_reg);
    assign src_ready     = (state_reg == HDR) || ((state_reg == PAYLOAD) && payload_ready);
    assign tgt_data      = src_data;
    assign tgt_valid     = ((state_reg == PAYLOAD) && src_valid && !abort) ? sel_reg : '0;
    assign hs            = src_valid && src_ready;
    assign can_start     = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));

    assign busy      = (state_reg == HDR) || (state_reg == PAYLOAD);
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;
    assign seg_count = seg_count_reg;

`ifdef GC_CFG_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_reg;

    assign end_ok = (src_data[CSUM_MSB:CSUM_LSB] == csum_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csum_reg <= '0;
        end else if (abort || can_start) begin
            csum_reg <= '0;
        end else if ((state_reg == PAYLOAD) && hs) begin
            csum_reg <= csum_reg + src_data[CSUM_MSB:CSUM_LSB];
        end
    end
`else
    assign end_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            remaining_reg <= '0;
            seg_count_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else if (abort) begin
            // A word handshaken in this cycle is dropped on the floor.
            state_reg     <= IDLE;
            sel_reg       <= '0;
            remaining_reg <= '0;
            seg_count_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (can_start) begin
                        state_reg     <= HDR;
                        seg_count_reg <= '0;
                        done_reg      <= 1'b0;
                        err_reg       <= 1'b0;
                        err_code_reg  <= ERR_NONE;
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (hdr_is_seg) begin
                            if (hdr_tgt_oob) begin
                                state_reg    <= ERR;
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_TGT;
                            end else if (hdr_len == '0) begin
                                seg_count_reg <= sat_inc8(seg_count_reg);
                            end else begin
                                state_reg     <= PAYLOAD;
                                sel_reg       <= sel_dec;
                                remaining_reg <= hdr_len;
                            end
                        end else if (hdr_is_end) begin
                            if (end_ok) begin
                                state_reg <= DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg    <= ERR;
                                err_reg      <= 1'b1;
                                err_code_reg <= ERR_CSUM;
                            end
                        end else if (hdr_is_illegal) begin
                            state_reg    <= ERR;
                            err_reg      <= 1'b1;
                            err_code_reg <= ERR_OPC;
                        end
                    end
                end
                PAYLOAD: begin
                    if (hs) begin
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1)) begin
                            state_reg     <= HDR;
                            seg_count_reg <= sat_inc8(seg_count_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gc_config_dispatcher.sv
// Scoreboard bench for gc_config_dispatcher; checksum scenarios run when
// GC_CFG_CHECKSUM_EN is defined.
module tb_gc_config_dispatcher;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [31:0]   src_data;
    logic          src_valid;
    logic          src_ready;
    logic [31:0]   tgt_data;
    logic [NT-1:0] tgt_valid;
    logic [NT-1:0] tgt_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    seg_count;

    int          total = 0;
    int          bad = 0;
    int          valid_cycles = 0;
    logic [35:0] sb[$];
    logic [15:0] csum = 16'h0;

    gc_config_dispatcher #(.NUM_TARGETS(NT), .LEN_W(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .tgt_data  (tgt_data),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .seg_count (seg_count)
    );

    always #5 clk = ~clk;

    // Output monitor: every target handshake pops the next expected word.
    always @(negedge clk) begin
        logic [35:0]   e;
        logic [NT-1:0] one;
        if (resetn === 1'b1 && tgt_valid !== '0) begin
            valid_cycles++;
            total++;
            if ($countones(tgt_valid) != 1) begin
                bad++;
                $display("FAIL onehot: tgt_valid=%b", tgt_valid);
            end
            if ((tgt_valid & tgt_ready) !== '0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: tgt_valid=%b data=%08h, nothing expected", tgt_valid, tgt_data);
                end else begin
                    e   = sb.pop_front();
                    one = 4'b0001;
                    one = one << e[35:32];
                    $display("xfer tgt_valid=%b data=%08h", tgt_valid, tgt_data);
                    if (tgt_data !== e[31:0] || tgt_valid !== one) begin
                        bad++;
                        $display("FAIL xfer: got valid=%b data=%08h want valid=%b data=%08h",
                                 tgt_valid, tgt_data, one, e[31:0]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] hdr(input logic [3:0] op, input logic [3:0] id, input logic [15:0] len);
        return {op, id, 8'h00, len};
    endfunction

    function automatic logic [31:0] end_hdr();
`ifdef GC_CFG_CHECKSUM_EN
        return {4'hF, 12'h000, csum};
`else
        return {4'hF, 12'h000, 16'hBEEF};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        csum  = 16'h0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 0;
        src_data  = w;
        src_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (src_ready === 1'b1) ok = 1;
            tick();
        end
        src_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: word %08h not accepted, required within 50 cycles", w);
        end
    endtask

    task automatic send_payload(input logic [3:0] id, input logic [31:0] w);
        sb.push_back({id, w});
        csum = csum + w[15:0];
        send_word(w);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({src_ready, busy, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got rdy/busy/done/err=%b want 0000", {src_ready, busy, done, err});
        end
        total++;
        if (tgt_valid !== '0 || err_code !== 2'd0 || seg_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_vals: got tv=%b ec=%0d sc=%0d want 0 0 0", tgt_valid, err_code, seg_count);
        end
        tick();
    endtask

    task automatic test_basic();
        pulse_start();
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || src_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_hdr: got busy=%b rdy=%b done=%b want 1 1 0", busy, src_ready, done);
        end
        tick();
        valid_cycles = 0;
        send_word(hdr(4'h1, 4'd1, 16'd3));
        send_payload(4'd1, 32'hA000_0001);
        send_payload(4'd1, 32'hA000_0002);
        send_payload(4'd1, 32'hA000_0003);
        send_word(end_hdr());
        @(negedge clk);
        total++;
        if (done !== 1'b1 || seg_count !== 8'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: got done=%b sc=%0d busy=%b want 1 1 0", done, seg_count, busy);
        end
        total++;
        if (valid_cycles != 3) begin
            bad++;
            $display("FAIL basic_valid_cycles: got %0d want 3", valid_cycles);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] words[3] = '{32'hB000_0011, 32'hB000_0022, 32'hB000_0033};
        bit          pat[5] = '{1, 0, 0, 1, 1};
        int          idx = 0;
        pulse_start();
        send_word(hdr(4'h1, 4'd1, 16'd3));
        for (int i = 0; i < 3; i++) begin
            sb.push_back({4'd1, words[i]});
            csum = csum + words[i][15:0];
        end
        for (int k = 0; k < 5; k++) begin
            tgt_ready = {2'b11, pat[k], 1'b1};
            src_data  = words[idx];
            src_valid = 1'b1;
            @(negedge clk);
            total++;
            if (src_ready !== pat[k] || tgt_valid !== 4'b0010) begin
                bad++;
                $display("FAIL bp_cycle%0d: got rdy=%b tv=%b want rdy=%b tv=0010", k, src_ready, tgt_valid, pat[k]);
            end
            if (pat[k]) idx++;
            tick();
        end
        src_valid = 1'b0;
        tgt_ready = '1;
        @(negedge clk);
        total++;
        if (sb.size() != 0 || busy !== 1'b1 || src_ready !== 1'b1 || seg_count !== 8'd1) begin
            bad++;
            $display("FAIL bp_after: got pending=%0d busy=%b rdy=%b sc=%0d want 0 1 1 1",
                     sb.size(), busy, src_ready, seg_count);
        end
        tick();
        send_word(end_hdr());
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL bp_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_zero_len();
        pulse_start();
        valid_cycles = 0;
        send_word(hdr(4'h1, 4'd2, 16'd0));
        send_word(end_hdr());
        @(negedge clk);
        total++;
        if (valid_cycles != 0 || seg_count !== 8'd1 || done !== 1'b1) begin
            bad++;
            $display("FAIL zero_len: got vcyc=%0d sc=%0d done=%b want 0 1 1", valid_cycles, seg_count, done);
        end
        tick();
    endtask

    task automatic test_errors();
        pulse_start();
        send_word(32'h1500_0002);
        src_data  = 32'h1234_5678;
        src_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (err !== 1'b1 || err_code !== 2'd2 || src_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_tgt%0d: got err=%b ec=%0d rdy=%b busy=%b want 1 2 0 0",
                         k, err, err_code, src_ready, busy);
            end
            tick();
        end
        src_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        total++;
        if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL err_restart: got err=%b ec=%0d busy=%b want 0 0 1", err, err_code, busy);
        end
        tick();
        send_word(hdr(4'h1, 4'd3, 16'd1));
        send_payload(4'd3, 32'hC0DE_0003);
        send_word(end_hdr());
        @(negedge clk);
        total++;
        if (done !== 1'b1 || err !== 1'b0 || seg_count !== 8'd1) begin
            bad++;
            $display("FAIL err_clean: got done=%b err=%b sc=%0d want 1 0 1", done, err, seg_count);
        end
        tick();
        pulse_start();
        send_word(32'h7000_0001);
        @(negedge clk);
        total++;
        if (err !== 1'b1 || err_code !== 2'd1 || done !== 1'b0) begin
            bad++;
            $display("FAIL bad_opc: got err=%b ec=%0d done=%b want 1 1 0", err, err_code, done);
        end
        tick();
    endtask

    task automatic test_abort();
        pulse_start();
        send_word(hdr(4'h1, 4'd2, 16'd0));
        send_word(hdr(4'h1, 4'd0, 16'd4));
        send_payload(4'd0, 32'hD000_0001);
        send_payload(4'd0, 32'hD000_0002);
        src_data  = 32'hD000_0003;
        src_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        total++;
        if (src_ready !== 1'b1 || tgt_valid !== '0 || seg_count !== 8'd1) begin
            bad++;
            $display("FAIL abort_cycle: got rdy=%b tv=%b sc=%0d want 1 0 1", src_ready, tgt_valid, seg_count);
        end
        tick();
        abort     = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || seg_count !== 8'd0 || tgt_valid !== '0 || src_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_after: got busy=%b sc=%0d tv=%b rdy=%b done=%b want 0 0 0 0 0",
                     busy, seg_count, tgt_valid, src_ready, done);
        end
        tick();
        csum = 16'h0;
    endtask

    task automatic test_start_ignored();
        pulse_start();
        send_word(hdr(4'h1, 4'd1, 16'd0));
        pulse_start();
        @(negedge clk);
        total++;
        if (seg_count !== 8'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_in_hdr: got sc=%0d busy=%b want 1 1", seg_count, busy);
        end
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || seg_count !== 8'd0) begin
            bad++;
            $display("FAIL start_abort: got busy=%b sc=%0d want 0 0", busy, seg_count);
        end
        tick();
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < 260; i++) send_word(hdr(4'h1, 4'd0, 16'd0));
        @(negedge clk);
        total++;
        if (seg_count !== 8'hFF) begin
            bad++;
            $display("FAIL seg_sat: got %0d want 255", seg_count);
        end
        tick();
        send_word(end_hdr());
        @(negedge clk);
        total++;
        if (done !== 1'b1 || seg_count !== 8'hFF) begin
            bad++;
            $display("FAIL seg_sat_done: got done=%b sc=%0d want 1 255", done, seg_count);
        end
        tick();
    endtask

`ifdef GC_CFG_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_word(hdr(4'h1, 4'd0, 16'd2));
        send_payload(4'd0, 32'h0000_0001);
        send_payload(4'd0, 32'h0000_FFFF);
        send_word(32'hF000_0000);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL csum_ok: got done=%b err=%b want 1 0", done, err);
        end
        tick();
        pulse_start();
        send_word(hdr(4'h1, 4'd0, 16'd2));
        send_payload(4'd0, 32'h0000_0001);
        send_payload(4'd0, 32'h0000_FFFF);
        send_word(32'hF000_0001);
        @(negedge clk);
        total++;
        if (err !== 1'b1 || err_code !== 2'd3 || done !== 1'b0) begin
            bad++;
            $display("FAIL csum_bad: got err=%b ec=%0d done=%b want 1 3 0", err, err_code, done);
        end
        tick();
    endtask
`endif

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        src_data  = 32'h0;
        src_valid = 1'b0;
        tgt_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_errors();
        test_abort();
        test_start_ignored();
        test_saturation();
`ifdef GC_CFG_CHECKSUM_EN
        test_checksum();
`endif
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending words want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
